cnn_loop_scheduler: RTL and testbench

//  Sequences the tiled convolution loop nest that feeds the Tm x Tn output_loop datapath in cnn.

---
 rtl/cnn_loop_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_cnn_loop_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_loop_scheduler.sv
// Loop-nest sequencer for the tiled convolution datapath.
// Emits one registered index beat per valid/ready handshake.
module cnn_loop_scheduler #(
  parameter int N_p  = 4,
  parameter int M_p  = 4,
  parameter int K_p  = 2,
  parameter int R_p  = 16,
  parameter int C_p  = 16,
  parameter int S_p  = 1,
  parameter int Tn_p = 2,
  parameter int Tm_p = 2,
  localparam int MW  = (M_p > 2) ? $clog2(M_p) : 1,
  localparam int NW  = (N_p > 2) ? $clog2(N_p) : 1,
  localparam int RW  = (R_p > 2) ? $clog2(R_p) : 1,
  localparam int CW  = (C_p > 2) ? $clog2(C_p) : 1,
  localparam int KW  = (K_p > 2) ? $clog2(K_p) : 1,
  localparam int IRX = (R_p - 1) * S_p + K_p,
  localparam int ICX = (C_p - 1) * S_p + K_p,
  localparam int IRW = (IRX > 2) ? $clog2(IRX) : 1,
  localparam int ICW = (ICX > 2) ? $clog2(ICX) : 1
) (
  input  logic           clk_i,
  input  logic           reset_n_i,
  input  logic           start_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [MW-1:0]  to_o,
  output logic [NW-1:0]  ti_o,
  output logic [RW-1:0]  row_o,
  output logic [CW-1:0]  col_o,
  output logic [KW-1:0]  i_o,
  output logic [KW-1:0]  j_o,
  output logic [IRW-1:0] in_row_o,
  output logic [ICW-1:0] in_col_o,
  output logic           first_o,
  output logic           last_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [KW-1:0] K_MAX   = KW'(K_p - 1);
  localparam logic [CW-1:0] C_MAX   = CW'(C_p - 1);
  localparam logic [RW-1:0] R_MAX   = RW'(R_p - 1);
  localparam logic [NW-1:0] TI_MAX  = NW'(N_p - Tn_p);
  localparam logic [MW-1:0] TO_MAX  = MW'(M_p - Tm_p);
  localparam logic [NW-1:0] TI_STEP = NW'(Tn_p);
  localparam logic [MW-1:0] TO_STEP = MW'(Tm_p);
  localparam logic          LAST0   = (N_p == Tn_p) && (K_p == 1);

  state_t         r_state;
  logic           r_busy;
  logic           r_done;
  logic           r_valid;
  logic [MW-1:0]  r_to;
  logic [NW-1:0]  r_ti;
  logic [RW-1:0]  r_row;
  logic [CW-1:0]  r_col;
  logic [KW-1:0]  r_i;
  logic [KW-1:0]  r_j;
  logic [IRW-1:0] r_irow;
  logic [ICW-1:0] r_icol;
  logic           r_first;
  logic           r_last;

  logic           w_wj, w_wi, w_wc, w_wr, w_wti, w_wto;
  logic           w_c2, w_c3, w_c4, w_c5, w_final;
  logic [MW-1:0]  w_to_n;
  logic [NW-1:0]  w_ti_n;
  logic [RW-1:0]  w_row_n;
  logic [CW-1:0]  w_col_n;
  logic [KW-1:0]  w_i_n;
  logic [KW-1:0]  w_j_n;
  logic [IRW-1:0] w_irow_n;
  logic [ICW-1:0] w_icol_n;
  logic           w_first_n;
  logic           w_last_n;

  // Odometer: each counter advances only when every inner one wraps.
  always_comb begin
    w_wj    = (r_j == K_MAX);
    w_wi    = (r_i == K_MAX);
    w_wc    = (r_col == C_MAX);
    w_wr    = (r_row == R_MAX);
    w_wti   = (r_ti == TI_MAX);
    w_wto   = (r_to == TO_MAX);
    w_c2    = w_wj & w_wi;
    w_c3    = w_c2 & w_wc;
    w_c4    = w_c3 & w_wr;
    w_c5    = w_c4 & w_wti;
    w_final = w_c5 & w_wto;
    w_j_n   = w_wj ? '0 : r_j + 1'b1;
    w_i_n   = !w_wj ? r_i
            : (w_wi ? '0 : r_i + 1'b1);
    w_col_n = !w_c2 ? r_col
            : (w_wc ? '0 : r_col + 1'b1);
    w_row_n = !w_c3 ? r_row
            : (w_wr ? '0 : r_row + 1'b1);
    w_ti_n  = !w_c4 ? r_ti
            : (w_wti ? '0 : r_ti + TI_STEP);
    w_to_n  = !w_c5 ? r_to
            : (w_wto ? '0 : r_to + TO_STEP);
    w_irow_n  = IRW'(w_row_n * S_p + w_i_n);
    w_icol_n  = ICW'(w_col_n * S_p + w_j_n);
    w_first_n = (w_ti_n == '0) && (w_i_n == '0)
             && (w_j_n == '0);
    w_last_n  = (w_ti_n == TI_MAX) && (w_i_n == K_MAX)
             && (w_j_n == K_MAX);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_to    <= '0;
      r_ti    <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_irow  <= '0;
      r_icol  <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= LAST0;
          end
        end
        RUN: begin
          if (r_valid && ready_i) begin
            if (w_final) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_to    <= '0;
              r_ti    <= '0;
              r_row   <= '0;
              r_col   <= '0;
              r_i     <= '0;
              r_j     <= '0;
              r_irow  <= '0;
              r_icol  <= '0;
              r_first <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_to    <= w_to_n;
              r_ti    <= w_ti_n;
              r_row   <= w_row_n;
              r_col   <= w_col_n;
              r_i     <= w_i_n;
              r_j     <= w_j_n;
              r_irow  <= w_irow_n;
              r_icol  <= w_icol_n;
              r_first <= w_first_n;
              r_last  <= w_last_n;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign valid_o  = r_valid;
  assign to_o     = r_to;
  assign ti_o     = r_ti;
  assign row_o    = r_row;
  assign col_o    = r_col;
  assign i_o      = r_i;
  assign j_o      = r_j;
  assign in_row_o = r_irow;
  assign in_col_o = r_icol;
  assign first_o  = r_first;
  assign last_o   = r_last;

endmodule

// File: tb/tb_cnn_loop_scheduler.sv
// Bench for cnn_loop_scheduler: beats checked against an
// index model derived by div/mod of the beat number.
module tb_cnn_loop_scheduler;

  localparam int M = 4, N = 4, K = 2, R = 16, C = 16;
  localparam int S = 1, TN = 2, TM = 2;
  localparam int TOTAL = (M / TM) * (N / TN) * R * C * K * K;
  localparam int MW = 2, NW = 2, RW = 4, CW = 4, KW = 1;
  localparam int IRW = 5, ICW = 5;
  localparam int EW = 3 + MW + NW + RW + CW + 2 * KW
                    + IRW + ICW + 2;

  localparam int K2 = 3, R2 = 4, C2 = 4, S2 = 2;
  localparam int TOTAL2 = 2 * 2 * R2 * C2 * K2 * K2;
  localparam int RW2 = 2, CW2 = 2, KW2 = 2;
  localparam int IRW2 = 4, ICW2 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, ready = 1'b0;
  logic busy, done, valid, first, last;
  logic [MW-1:0]  to;
  logic [NW-1:0]  ti;
  logic [RW-1:0]  row;
  logic [CW-1:0]  col;
  logic [KW-1:0]  ii, jj;
  logic [IRW-1:0] irow;
  logic [ICW-1:0] icol;

  logic start2 = 1'b0, ready2 = 1'b0;
  logic busy2, done2, valid2, first2, last2;
  logic [1:0]      to2, ti2;
  logic [RW2-1:0]  row2;
  logic [CW2-1:0]  col2;
  logic [KW2-1:0]  ii2, jj2;
  logic [IRW2-1:0] irow2;
  logic [ICW2-1:0] icol2;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cnn_loop_scheduler dut (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start),
    .busy_o(busy), .done_o(done), .valid_o(valid),
    .ready_i(ready), .to_o(to), .ti_o(ti),
    .row_o(row), .col_o(col), .i_o(ii), .j_o(jj),
    .in_row_o(irow), .in_col_o(icol),
    .first_o(first), .last_o(last)
  );

  cnn_loop_scheduler #(
    .N_p(4), .M_p(4), .K_p(K2), .R_p(R2), .C_p(C2),
    .S_p(S2), .Tn_p(2), .Tm_p(2)
  ) dut2 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start2),
    .busy_o(busy2), .done_o(done2), .valid_o(valid2),
    .ready_i(ready2), .to_o(to2), .ti_o(ti2),
    .row_o(row2), .col_o(col2), .i_o(ii2), .j_o(jj2),
    .in_row_o(irow2), .in_col_o(icol2),
    .first_o(first2), .last_o(last2)
  );

  function automatic void dec(
    input int n, k, c, r, nt, tn, tm,
    output int o_to, o_ti, o_row, o_col, o_i, o_j);
    int q;
    o_j = n % k;   q = n / k;
    o_i = q % k;   q = q / k;
    o_col = q % c; q = q / c;
    o_row = q % r; q = q / r;
    o_ti = (q % nt) * tn;
    o_to = (q / nt) * tm;
  endfunction

  function automatic logic [EW-1:0] actual();
    return {valid, busy, done, to, ti, row, col, ii, jj,
            irow, icol, first, last};
  endfunction

  function automatic logic [EW-1:0] expect_beat(int n);
    int a, b, r, c, i, j;
    logic [MW-1:0] e_to;
    logic [NW-1:0] e_ti;
    logic [RW-1:0] e_row;
    logic [CW-1:0] e_col;
    logic [KW-1:0] e_i, e_j;
    logic [IRW-1:0] e_ir;
    logic [ICW-1:0] e_ic;
    logic e_f, e_l;
    if (n >= TOTAL)
      return {3'b001, {(EW - 3){1'b0}}};
    dec(n, K, C, R, N / TN, TN, TM, a, b, r, c, i, j);
    e_to = MW'(a);  e_ti = NW'(b);
    e_row = RW'(r); e_col = CW'(c);
    e_i = KW'(i);   e_j = KW'(j);
    e_ir = IRW'(r * S + i);
    e_ic = ICW'(c * S + j);
    e_f = (b == 0) && (i == 0) && (j == 0);
    e_l = (b == N - TN) && (i == K - 1) && (j == K - 1);
    return {3'b110, e_to, e_ti, e_row, e_col, e_i, e_j,
            e_ir, e_ic, e_f, e_l};
  endfunction

  task automatic run_pass(input int pct, input bit hold,
                          input int abort_at);
    int n = 0, cyc = 0, dones = 0;
    logic [EW-1:0] exp_v, act_v;
    @(negedge clk);
    start = 1'b1;
    ready = 1'b0;
    forever begin
      @(negedge clk);
      start = hold;
      cyc++;
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (actual() !== '0) begin
          n_fail++;
          $display("FAIL abort_reset got=%h exp=0", actual());
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      exp_v = expect_beat(n);
      act_v = actual();
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL beat n=%0d got=%h exp=%h",
                 n, act_v, exp_v);
      end
      if (done) dones++;
      if (n == 3) begin
        n_checks++;
        if ({ti, ii, jj, last} !== {2'd0, 1'b1, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL beat3 got=%h exp=%h",
                   {ti, ii, jj, last}, 5'b00110);
        end
      end
      if (n == 1027) begin
        n_checks++;
        if ({ti, ii, jj, last} !== {2'd2, 1'b1, 1'b1, 1'b1}) begin
          n_fail++;
          $display("FAIL beat1027 got=%h exp=%h",
                   {ti, ii, jj, last}, 5'b10111);
        end
      end
      if (n == 2048) begin
        n_checks++;
        if ({to, first} !== {2'd2, 1'b1}) begin
          n_fail++;
          $display("FAIL beat2048 got=%h exp=%h",
                   {to, first}, 3'b101);
        end
      end
      if (n == TOTAL) break;
      if (cyc > 4 * TOTAL + 10) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout beats=%0d need=%0d", n, TOTAL);
        break;
      end
      ready = ($urandom_range(99) < pct);
      if (ready) n++;
    end
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (actual() !== '0) begin
        n_fail++;
        $display("FAIL idle_after got=%h exp=0", actual());
      end
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++;
      $display("FAIL done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (actual() !== '0) begin
      n_fail++;
      $display("FAIL reset got=%h exp=0", actual());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (actual() !== '0) begin
      n_fail++;
      $display("FAIL reset_idle got=%h exp=0", actual());
    end
  endtask

  task automatic test_back_to_back();
    run_pass(100, 1'b0, -1);
  endtask

  task automatic test_random_ready();
    run_pass(50, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    run_pass(100, 1'b0, 100);
    run_pass(100, 1'b0, -1);
  endtask

  task automatic test_start_held();
    run_pass(100, 1'b1, -1);
    run_pass(100, 1'b0, -1);
  endtask

  task automatic test_stride();
    int n = 0, cyc = 0;
    int a, b, r, c, i, j;
    @(negedge clk);
    start2 = 1'b1;
    ready2 = 1'b1;
    forever begin
      @(negedge clk);
      start2 = 1'b0;
      cyc++;
      if (n == TOTAL2) begin
        n_checks++;
        if ({done2, valid2} !== 2'b10) begin
          n_fail++;
          $display("FAIL stride_done got=%b exp=10",
                   {done2, valid2});
        end
        break;
      end
      if (cyc > TOTAL2 + 10) begin
        n_checks++;
        n_fail++;
        $display("FAIL stride_timeout beats=%0d", n);
        break;
      end
      dec(n, K2, C2, R2, 2, 2, 2, a, b, r, c, i, j);
      n_checks++;
      if ({valid2, irow2, icol2} !==
          {1'b1, IRW2'(r * S2 + i), ICW2'(c * S2 + j)}) begin
        n_fail++;
        $display("FAIL stride_beat n=%0d got=%h exp=%h", n,
                 {valid2, irow2, icol2},
                 {1'b1, IRW2'(r * S2 + i), ICW2'(c * S2 + j)});
      end
      if (n == 133) begin
        n_checks++;
        if ({row2, col2, ii2, jj2, irow2, icol2} !==
            {2'd3, 2'd2, 2'd2, 2'd1, 4'd8, 4'd5}) begin
          n_fail++;
          $display("FAIL stride_point got=%h exp=%h",
                   {row2, col2, ii2, jj2, irow2, icol2},
                   {2'd3, 2'd2, 2'd2, 2'd1, 4'd8, 4'd5});
        end
      end
      n++;
    end
    ready2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random_ready();
    test_reset_mid();
    test_start_held();
    test_stride();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
